// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_pkg;

    // Hazard controller state, also exported on busy_state
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_DM_WAIT  = 2'd2
    } hz_state_t;

    // Operand source select encodings
    localparam logic [1:0] FWD_RF     = 2'd0;
    localparam logic [1:0] FWD_EXEMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB  = 2'd2;

    // Default parameter values
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_REG_AW   = 5;
    localparam int DEF_LOAD_LAT = 1;
    localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - combinational forwarding select for one decode-stage source operand
// Ports:
//   src_addr/src_read            decode-stage source register and its valid flag
//   mem_write_addr/mem_reg_write EXE/MEM destination (highest priority)
//   wb_write_addr/wb_reg_write   MEM/WB destination
//   fwd_sel                      0 regfile, 1 EXE/MEM result, 2 MEM/WB result
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic              src_read,
    input  logic [REG_AW-1:0] mem_write_addr,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] wb_write_addr,
    input  logic              wb_reg_write,
    output logic [1:0]        fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        // r0 is hard-wired zero and is never forwarded
        if (src_read && (src_addr != '0)) begin
            if (mem_reg_write && (mem_write_addr == src_addr)) begin
                fwd_sel = FWD_EXEMEM;
            end else if (wb_reg_write && (wb_write_addr == src_addr)) begin
                fwd_sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - forwarding, load-use/branch/memory-wait hazard control and perf counters
// Ports:
//   clk, rst (async active-low)
//   id_*        decode-stage source addresses and read flags
//   exe_*/mem_*/wb_*  later-stage destinations, write enables, load flag
//   branch_true taken branch in EXE; dm_busy data memory not ready
//   fwd_sel*    operand source selects
//   *_stall, *_flush  pipeline register controls
//   stall_cnt, flush_cnt  saturating counters; busy_state current state
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_reg1_addr,
    input  logic [REG_AW-1:0] id_reg2_addr,
    input  logic [REG_AW-1:0] id_sw_addr,
    input  logic              id_reg1_read,
    input  logic              id_reg2_read,
    input  logic              id_sw_read,
    input  logic [REG_AW-1:0] exe_write_addr,
    input  logic              exe_reg_write,
    input  logic              exe_DM_read,
    input  logic [REG_AW-1:0] mem_write_addr,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] wb_write_addr,
    input  logic              wb_reg_write,
    input  logic              branch_true,
    input  logic              dm_busy,
    output logic [1:0]        fwd_sel1,
    output logic [1:0]        fwd_sel2,
    output logic [1:0]        fwd_selsw,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              idexe_stall,
    output logic              exemem_stall,
    output logic              ifid_flush,
    output logic              idexe_flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [1:0]        busy_state
);

    if (LOAD_LAT < 1 || LOAD_LAT > 7 || DATA_W < 1) begin : g_param_check
        $error("pipe_hazard_ctrl: LOAD_LAT must be 1..7 and DATA_W positive");
    end

    localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);

    hz_state_t  state, state_nx;
    logic [2:0] lu_cnt, lu_cnt_nx;
    logic       armed;
    logic       load_use;

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_reg1 (
        .src_addr(id_reg1_addr), .src_read(id_reg1_read),
        .mem_write_addr(mem_write_addr), .mem_reg_write(mem_reg_write),
        .wb_write_addr(wb_write_addr), .wb_reg_write(wb_reg_write),
        .fwd_sel(fwd_sel1)
    );
    fwd_unit #(.REG_AW(REG_AW)) u_fwd_reg2 (
        .src_addr(id_reg2_addr), .src_read(id_reg2_read),
        .mem_write_addr(mem_write_addr), .mem_reg_write(mem_reg_write),
        .wb_write_addr(wb_write_addr), .wb_reg_write(wb_reg_write),
        .fwd_sel(fwd_sel2)
    );
    fwd_unit #(.REG_AW(REG_AW)) u_fwd_sw (
        .src_addr(id_sw_addr), .src_read(id_sw_read),
        .mem_write_addr(mem_write_addr), .mem_reg_write(mem_reg_write),
        .wb_write_addr(wb_write_addr), .wb_reg_write(wb_reg_write),
        .fwd_sel(fwd_selsw)
    );

    assign load_use = exe_DM_read && exe_reg_write && (exe_write_addr != '0) &&
                      ((id_reg1_read && (id_reg1_addr == exe_write_addr)) ||
                       (id_reg2_read && (id_reg2_addr == exe_write_addr)) ||
                       (id_sw_read   && (id_sw_addr   == exe_write_addr)));

    // armed stays low through reset and the first cycle after release so that
    // only dm_busy can drive the controls before the pipeline is live
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_RUN;
            lu_cnt <= '0;
            armed  <= 1'b0;
        end else begin
            state  <= state_nx;
            lu_cnt <= lu_cnt_nx;
            armed  <= 1'b1;
        end
    end

    // DM_WAIT with dm_busy low is the release cycle: it behaves like RUN so a
    // load-use that was frozen behind the memory wait is still caught
    always_comb begin
        state_nx  = state;
        lu_cnt_nx = lu_cnt;
        if (dm_busy) begin
            state_nx  = ST_DM_WAIT;
            lu_cnt_nx = '0;
        end else if (!armed || branch_true) begin
            state_nx  = ST_RUN;
            lu_cnt_nx = '0;
        end else begin
            case (state)
                ST_LU_STALL: begin
                    lu_cnt_nx = lu_cnt - 3'd1;
                    if (lu_cnt == 3'd1) begin
                        state_nx = ST_RUN;
                    end
                end
                default: begin
                    state_nx  = ST_RUN;
                    lu_cnt_nx = '0;
                    if (load_use && (LOAD_LAT > 1)) begin
                        state_nx  = ST_LU_STALL;
                        lu_cnt_nx = LU_INIT;
                    end
                end
            endcase
        end
    end

    always_comb begin
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        idexe_stall  = 1'b0;
        exemem_stall = 1'b0;
        ifid_flush   = 1'b0;
        idexe_flush  = 1'b0;
        if (dm_busy) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idexe_stall  = 1'b1;
            exemem_stall = 1'b1;
        end else if (armed) begin
            if (branch_true) begin
                ifid_flush  = 1'b1;
                idexe_flush = 1'b1;
            end else if (state == ST_LU_STALL) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idexe_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (ifid_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign busy_state = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl with LOAD_LAT 1 and 3
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_reg1_addr, id_reg2_addr, id_sw_addr;
    logic       id_reg1_read, id_reg2_read, id_sw_read;
    logic [4:0] exe_write_addr, mem_write_addr, wb_write_addr;
    logic       exe_reg_write, exe_DM_read, mem_reg_write, wb_reg_write;
    logic       branch_true, dm_busy;

    logic [1:0]  fs1 [2];
    logic [1:0]  fs2 [2];
    logic [1:0]  fss [2];
    logic        pc_s [2];
    logic        ifid_s [2];
    logic        idexe_s [2];
    logic        exemem_s [2];
    logic        ifid_f [2];
    logic        idexe_f [2];
    logic [1:0]  bs [2];
    logic [15:0] sc0, fc0;
    logic [3:0]  sc1, fc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DATA_W(32), .REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst),
        .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr), .id_sw_addr(id_sw_addr),
        .id_reg1_read(id_reg1_read), .id_reg2_read(id_reg2_read), .id_sw_read(id_sw_read),
        .exe_write_addr(exe_write_addr), .exe_reg_write(exe_reg_write), .exe_DM_read(exe_DM_read),
        .mem_write_addr(mem_write_addr), .mem_reg_write(mem_reg_write),
        .wb_write_addr(wb_write_addr), .wb_reg_write(wb_reg_write),
        .branch_true(branch_true), .dm_busy(dm_busy),
        .fwd_sel1(fs1[0]), .fwd_sel2(fs2[0]), .fwd_selsw(fss[0]),
        .pc_stall(pc_s[0]), .ifid_stall(ifid_s[0]), .idexe_stall(idexe_s[0]),
        .exemem_stall(exemem_s[0]), .ifid_flush(ifid_f[0]), .idexe_flush(idexe_f[0]),
        .stall_cnt(sc0), .flush_cnt(fc0), .busy_state(bs[0])
    );

    pipe_hazard_ctrl #(.DATA_W(32), .REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst),
        .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr), .id_sw_addr(id_sw_addr),
        .id_reg1_read(id_reg1_read), .id_reg2_read(id_reg2_read), .id_sw_read(id_sw_read),
        .exe_write_addr(exe_write_addr), .exe_reg_write(exe_reg_write), .exe_DM_read(exe_DM_read),
        .mem_write_addr(mem_write_addr), .mem_reg_write(mem_reg_write),
        .wb_write_addr(wb_write_addr), .wb_reg_write(wb_reg_write),
        .branch_true(branch_true), .dm_busy(dm_busy),
        .fwd_sel1(fs1[1]), .fwd_sel2(fs2[1]), .fwd_selsw(fss[1]),
        .pc_stall(pc_s[1]), .ifid_stall(ifid_s[1]), .idexe_stall(idexe_s[1]),
        .exemem_stall(exemem_s[1]), .ifid_flush(ifid_f[1]), .idexe_flush(idexe_f[1]),
        .stall_cnt(sc1), .flush_cnt(fc1), .busy_state(bs[1])
    );

    // ---------------- behavioural model ----------------
    // Per instance: live flag, extra stall cycles still owed, memory-wait flag,
    // and the two counters as plain integers.
    int m_live   [2] = '{0, 0};
    int m_remain [2] = '{0, 0};
    int m_dmwait [2] = '{0, 0};
    int m_sc     [2] = '{0, 0};
    int m_fc     [2] = '{0, 0};

    typedef struct {
        int pc; int ifid; int idexe; int exemem; int fl_if; int fl_idexe; int bstate;
    } exp_t;

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int cmax_of(int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    function automatic int exp_fwd(int a, int rd);
        if (rd == 0 || a == 0) return 0;
        if (mem_reg_write && int'(mem_write_addr) == a) return 1;
        if (wb_reg_write && int'(wb_write_addr) == a) return 2;
        return 0;
    endfunction

    function automatic int hazard();
        int d;
        d = int'(exe_write_addr);
        if (!(exe_DM_read && exe_reg_write) || d == 0) return 0;
        return ((id_reg1_read && int'(id_reg1_addr) == d) ||
                (id_reg2_read && int'(id_reg2_addr) == d) ||
                (id_sw_read   && int'(id_sw_addr)   == d)) ? 1 : 0;
    endfunction

    function automatic exp_t model_out(int k);
        exp_t e;
        e = '{0, 0, 0, 0, 0, 0, 0};
        e.bstate = m_dmwait[k] ? 2 : ((m_remain[k] > 0) ? 1 : 0);
        if (dm_busy) begin
            e.pc = 1; e.ifid = 1; e.idexe = 1; e.exemem = 1;
        end else if (m_live[k] != 0) begin
            if (branch_true) begin
                e.fl_if = 1; e.fl_idexe = 1;
            end else if (m_remain[k] > 0) begin
                e.pc = 1; e.ifid = 1;
            end else if (hazard() != 0) begin
                e.pc = 1; e.ifid = 1; e.fl_idexe = 1;
            end
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_live[k] = 0; m_remain[k] = 0; m_dmwait[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                exp_t e;
                e = model_out(k);
                if (e.pc != 0 && m_sc[k] < cmax_of(k)) m_sc[k] = m_sc[k] + 1;
                if (e.fl_if != 0 && m_fc[k] < cmax_of(k)) m_fc[k] = m_fc[k] + 1;
                if (dm_busy) begin
                    m_remain[k] = 0; m_dmwait[k] = 1;
                end else begin
                    m_dmwait[k] = 0;
                    if (m_live[k] == 0 || branch_true) m_remain[k] = 0;
                    else if (m_remain[k] > 0) m_remain[k] = m_remain[k] - 1;
                    else if (hazard() != 0) m_remain[k] = lat_of(k) - 1;
                end
                m_live[k] = 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge, both instances against the model
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            e = model_out(k);
            chk($sformatf("m%0d_fwd1", k), int'(fs1[k]), exp_fwd(int'(id_reg1_addr), int'(id_reg1_read)));
            chk($sformatf("m%0d_fwd2", k), int'(fs2[k]), exp_fwd(int'(id_reg2_addr), int'(id_reg2_read)));
            chk($sformatf("m%0d_fwdsw", k), int'(fss[k]), exp_fwd(int'(id_sw_addr), int'(id_sw_read)));
            chk($sformatf("m%0d_pc_stall", k), int'(pc_s[k]), e.pc);
            chk($sformatf("m%0d_ifid_stall", k), int'(ifid_s[k]), e.ifid);
            chk($sformatf("m%0d_idexe_stall", k), int'(idexe_s[k]), e.idexe);
            chk($sformatf("m%0d_exemem_stall", k), int'(exemem_s[k]), e.exemem);
            chk($sformatf("m%0d_ifid_flush", k), int'(ifid_f[k]), e.fl_if);
            chk($sformatf("m%0d_idexe_flush", k), int'(idexe_f[k]), e.fl_idexe);
            chk($sformatf("m%0d_busy_state", k), int'(bs[k]), e.bstate);
            chk($sformatf("m%0d_stall_cnt", k), (k == 0) ? int'(sc0) : int'(sc1), m_sc[k]);
            chk($sformatf("m%0d_flush_cnt", k), (k == 0) ? int'(fc0) : int'(fc1), m_fc[k]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        id_reg1_addr = '0; id_reg2_addr = '0; id_sw_addr = '0;
        id_reg1_read = 0;  id_reg2_read = 0;  id_sw_read = 0;
        exe_write_addr = '0; exe_reg_write = 0; exe_DM_read = 0;
        mem_write_addr = '0; mem_reg_write = 0;
        wb_write_addr = '0;  wb_reg_write = 0;
        branch_true = 0; dm_busy = 0;
    endtask

    task automatic lw_r3_use();
        exe_DM_read = 1; exe_reg_write = 1; exe_write_addr = 5'd3;
        id_reg1_addr = 5'd3; id_reg1_read = 1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        #1 rst = 1'b0;
        @(posedge clk); #1;
        #4;
        chk("lit_reset_state", int'(bs[0]), 0);
        chk("lit_reset_stall_cnt", int'(sc0), 0);
        dm_busy = 1; #1;
        chk("lit_reset_dm_busy_stall", int'(exemem_s[1]), 1);
        dm_busy = 0;
        // release: the first cycle must ignore a load-use
        nxt(); rst = 1'b1; lw_r3_use();
        #4 chk("lit_first_cycle_gated", int'(pc_s[0]), 0);

        nxt(); lw_r3_use();
        #4;
        chk("lit_lu_pc_stall_l1", int'(pc_s[0]), 1);
        chk("lit_lu_idexe_flush_l1", int'(idexe_f[0]), 1);
        chk("lit_lu_pc_stall_l3", int'(pc_s[1]), 1);
        nxt(); id_reg1_addr = 5'd3; id_reg1_read = 1; wb_write_addr = 5'd3; wb_reg_write = 1;
        #4;
        chk("lit_fwd_wb", int'(fs1[0]), 2);
        chk("lit_l1_stall_done", int'(pc_s[0]), 0);
        chk("lit_l3_lu_state", int'(bs[1]), 1);
        nxt();
        #4;
        chk("lit_l3_stall3", int'(pc_s[1]), 1);
        chk("lit_l1_stall_cnt", int'(sc0), 1);
        nxt();
        #4;
        chk("lit_l3_back_run", int'(bs[1]), 0);
        chk("lit_l3_stall_cnt", int'(sc1), 3);

        nxt(); mem_write_addr = 5'd5; mem_reg_write = 1; wb_write_addr = 5'd5; wb_reg_write = 1;
        id_reg1_addr = 5'd5; id_reg1_read = 1;
        #4 chk("lit_fwd_mem_wins", int'(fs1[0]), 1);
        nxt(); mem_reg_write = 1; wb_reg_write = 1; id_reg1_read = 1;
        #4 chk("lit_fwd_r0", int'(fs1[0]), 0);

        nxt(); lw_r3_use(); branch_true = 1;
        #4;
        chk("lit_br_ifid_flush", int'(ifid_f[0]), 1);
        chk("lit_br_idexe_flush", int'(idexe_f[1]), 1);
        chk("lit_br_no_stall", int'(pc_s[1]), 0);
        nxt(); lw_r3_use();
        #4;
        chk("lit_br_flush_cnt", int'(fc1), 1);
        for (int i = 0; i < 4; i++) begin
            nxt(); dm_busy = 1;
            #4;
            chk("lit_dm_exemem_stall", int'(exemem_s[1]), 1);
            chk("lit_dm_no_flush", int'(ifid_f[1]), 0);
            chk("lit_dm_state", int'(bs[1]), (i == 0) ? 1 : 2);
        end
        nxt();
        #4;
        chk("lit_dm_release_state", int'(bs[1]), 2);
        chk("lit_dm_release_stall", int'(pc_s[1]), 0);
        nxt();
        #4 chk("lit_dm_back_run", int'(bs[1]), 0);
        nxt(); dm_busy = 1;
        nxt(); dm_busy = 1;
        nxt(); rst = 1'b0;
        #4;
        chk("lit_rst_dm_state", int'(bs[1]), 0);
        chk("lit_rst_stall_cnt", int'(sc1), 0);
        chk("lit_rst_flush_cnt", int'(fc0), 0);
        nxt(); rst = 1'b1;

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            nxt();
            rst            = ($urandom_range(0, 99) < 1) ? 1'b0 : 1'b1;
            id_reg1_addr   = 5'($urandom_range(0, 3));
            id_reg2_addr   = 5'($urandom_range(0, 3));
            id_sw_addr     = 5'($urandom_range(0, 3));
            id_reg1_read   = 1'($urandom_range(0, 1));
            id_reg2_read   = 1'($urandom_range(0, 1));
            id_sw_read     = 1'($urandom_range(0, 1));
            exe_write_addr = 5'($urandom_range(0, 3));
            exe_reg_write  = 1'($urandom_range(0, 1));
            exe_DM_read    = 1'($urandom_range(0, 1));
            mem_write_addr = 5'($urandom_range(0, 3));
            mem_reg_write  = 1'($urandom_range(0, 1));
            wb_write_addr  = 5'($urandom_range(0, 3));
            wb_reg_write   = 1'($urandom_range(0, 1));
            branch_true    = ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0;
            dm_busy        = ($urandom_range(0, 99) < 12) ? 1'b1 : 1'b0;
        end
        nxt();
        rst = 1'b1;
        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter REG_AW, default 5, register address width.
REQ-003 SHALL have parameter LOAD_LAT, default 1, load-use penalty in cycles, legal range 1..7.
REQ-004 SHALL have parameter CNT_W, default 16, performance counter width.
REQ-005 SHALL have ports: clk  in  1  sole clock; reset is asynchronous and active-low; rst  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: id_reg1_addr / id_reg2_addr / id_sw_addr  in  REG_AW each  decode-stage source addresses; id_reg1_read / id_reg2_read / id_sw_read  in  1 each  source-valid flags.
REQ-007 SHALL have ports: exe_write_addr  in  REG_AW; exe_reg_write  in  1; exe_DM_read  in  1  EXE-stage destination, write enable and load flag.
REQ-008 SHALL have ports: mem_write_addr  in  REG_AW; mem_reg_write  in  1; wb_write_addr  in  REG_AW; wb_reg_write  in  1  later-stage destinations.
REQ-009 SHALL have ports: branch_true  in  1  taken branch resolved in EXE; dm_busy  in  1  data memory not ready.
REQ-010 SHALL have ports: fwd_sel1 / fwd_sel2 / fwd_selsw  out  2 each  operand source select (0 regfile, 1 EXE/MEM result, 2 MEM/WB result).
REQ-011 SHALL have ports: pc_stall, ifid_stall, idexe_stall, exemem_stall, ifid_flush, idexe_flush  out  1 each  pipeline register controls.
REQ-012 SHALL have ports: stall_cnt, flush_cnt  out  CNT_W each  performance counters; busy_state  out  2  current FSM state.

Function
REQ-013 SHALL set each fwd_sel combinationally: 1 if the source is read, address nonzero, equals mem_write_addr and mem_reg_write; else 2 on the same test against wb; else 0; EXE/MEM wins when both match.
REQ-014 SHALL never forward register 0; its select SHALL be 0.
REQ-015 SHALL detect load-use when exe_DM_read & exe_reg_write & exe_write_addr nonzero and equal to any read ID source.
REQ-016 SHALL implement FSM states RUN (0), LU_STALL (1), DM_WAIT (2).
REQ-017 In RUN with load-use and no branch_true, SHALL assert pc_stall, ifid_stall, idexe_flush that cycle; if LOAD_LAT>1 SHALL enter LU_STALL loading a down-counter with LOAD_LAT-1.
REQ-018 In LU_STALL SHALL assert pc_stall and ifid_stall each cycle, decrement the counter, return to RUN the cycle the counter reaches 1 -> 0.
REQ-019 On branch_true with dm_busy low SHALL assert ifid_flush and idexe_flush, suppress load-use stall, and force RUN from any state.
REQ-020 On dm_busy high SHALL assert all four *_stall outputs, deassert both flushes, enter DM_WAIT; SHALL return to RUN the cycle after dm_busy falls; the LU_STALL counter is abandoned.
REQ-021 dm_busy SHALL take priority over branch_true and load-use.
REQ-022 stall_cnt SHALL increment on each cycle pc_stall is high; flush_cnt on each cycle ifid_flush is high; both saturate at all-ones.

Reset
REQ-023 On rst low SHALL asynchronously enter RUN, clear LU counter, stall_cnt and flush_cnt; all stall/flush outputs SHALL read 0 during reset and first cycle after release unless dm_busy is high.
REQ-024 Reset asserted mid-LU_STALL or DM_WAIT SHALL abandon the stall with no residual effect.

Structure
REQ-025 SHALL place FSM state enum, fwd_sel encodings and default parameter constants in a shared package pipe_pkg.
REQ-026 SHALL instantiate one sub-module fwd_unit, combinational, three instances, one per source.

Verification
REQ-027 lw r3 in EXE, add using r3 in ID, LOAD_LAT=1 -> one cycle pc_stall/ifid_stall/idexe_flush, stall_cnt=1, fwd_sel1=2 next-next cycle.
REQ-028 LOAD_LAT=3 same hazard -> pc_stall high 3 consecutive cycles, busy_state 1 for 2 cycles, stall_cnt=3.
REQ-029 r5 written in both MEM and WB, ID reads r5 -> fwd_sel1=1; write to r0 -> fwd_sel=0.
REQ-030 branch_true coincident with load-use -> ifid_flush=idexe_flush=1, pc_stall=0, flush_cnt=1.
REQ-031 dm_busy high 4 cycles during LU_STALL -> all stalls high 4 cycles, busy_state 2, then RUN; rst low mid-DM_WAIT -> counters 0, state RUN.
